// File: rtl/rv32_load_store_unit_if.sv
// Core-side request/response and data-memory bus signals of the RV32I load/store unit.
// The LSU connects through the slave modport; the core/memory side uses master.
interface rv32_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/rv32_load_store_unit.sv
// RV32I data-memory load/store unit: one access at a time over a req/gnt/rvalid bus,
// with lane steering, load extension, misalignment/illegal-funct3 checks and a bus timeout.
module rv32_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input logic                    clk,
  input logic                    rst,
  rv32_load_store_unit_if.slave  bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                cap_we_q, cap_we_n;
  logic [2:0]          cap_f3_q, cap_f3_n;
  logic [XLEN-1:0]     cap_addr_q, cap_addr_n;
  logic [XLEN-1:0]     cap_wdata_q, cap_wdata_n;
  logic                timeout_c;

  logic                ready_q, ready_n;
  logic                resp_valid_q, resp_valid_n;
  logic [XLEN-1:0]     rdata_q, rdata_n;
  logic                err_q, err_n;
  logic                stall_q, stall_n;
  logic                mem_req_q, mem_req_n;
  logic                mem_we_q, mem_we_n;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_n;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_n;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_n;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    if ((f3[1:0] == 2'b01) && off[0])         bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [STRB_W-1:0] s;
    unique case (f3[1:0])
      2'b00:   s = STRB_W'(4'b0001) << off;
      2'b01:   s = STRB_W'(4'b0011) << off;
      default: s = '1;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] d;
    unique case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh, d;
    sh = rd >> {off, 3'b000};
    unique case (f3[1:0])
      2'b00:   d = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   d = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: d = rd;
    endcase
    return d;
  endfunction

  // Next-state, capture and registered-output logic
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    cap_we_n    = cap_we_q;
    cap_f3_n    = cap_f3_q;
    cap_addr_n  = cap_addr_q;
    cap_wdata_n = cap_wdata_q;
    rdata_n     = '0;
    err_n       = 1'b0;
    timeout_c   = TO_EN && (cnt_q >= TO_LAST);

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cap_we_n    = bus.req_we;
          cap_f3_n    = bus.req_funct3;
          cap_addr_n  = bus.req_addr;
          cap_wdata_n = bus.req_wdata;
          cnt_n       = '0;
          if (is_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (bus.mem_gnt) begin
          state_n = cap_we_q ? RESP : WAIT;
        end else if (timeout_c) begin
          state_n = RESP;
          err_n   = 1'b1;
        end
      end
      WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (bus.mem_rvalid) begin
          state_n = RESP;
          rdata_n = load_ext(cap_f3_q, cap_addr_q[1:0], bus.mem_rdata);
        end else if (timeout_c) begin
          state_n = RESP;
          err_n   = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    ready_n      = (state_n == IDLE);
    stall_n      = (state_n != IDLE);
    resp_valid_n = (state_n == RESP);
    mem_req_n    = (state_n == REQ);
    mem_we_n     = mem_req_n && cap_we_n;
    mem_addr_n   = mem_req_n ? {cap_addr_n[XLEN-1:2], 2'b00} : '0;
    mem_wstrb_n  = mem_we_n ? lane_strb(cap_f3_n, cap_addr_n[1:0]) : '0;
    mem_wdata_n  = mem_we_n ? lane_wdata(cap_f3_n, cap_wdata_n) : '0;
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_we_q     <= 1'b0;
      cap_f3_q     <= '0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      cap_we_q     <= cap_we_n;
      cap_f3_q     <= cap_f3_n;
      cap_addr_q   <= cap_addr_n;
      cap_wdata_q  <= cap_wdata_n;
      ready_q      <= ready_n;
      resp_valid_q <= resp_valid_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
      stall_q      <= stall_n;
      mem_req_q    <= mem_req_n;
      mem_we_q     <= mem_we_n;
      mem_addr_q   <= mem_addr_n;
      mem_wstrb_q  <= mem_wstrb_n;
      mem_wdata_q  <= mem_wdata_n;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.stall      = stall_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Scoreboard bench for rv32_load_store_unit: stimulus acts as core and memory,
// a separate monitor checks every response against an arithmetic reference model.
module tb_rv32_load_store_unit;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  rv32_load_store_unit_if bus ();

  rv32_load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: byte-count arithmetic on the access, not lane muxes
  function automatic logic m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    nbytes = 1 << int'(f3[1:0]);
    return (int'(a[1:0]) % nbytes) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int nbytes;
    longint unsigned v, span;
    nbytes = 1 << int'(f3[1:0]);
    if (nbytes == 4) return w;
    span = 64'd1 << (8 * nbytes);
    v = (64'(w) >> (8 * int'(a[1:0]))) % span;
    if (f3 < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << int'(f3[1:0]);
    return 32'(((1 << nbytes) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // Response monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(e.err));
          check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    @(negedge clk);
    for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int gd, input int rd, input logic early_rv);
    exp_t e;
    logic ill, req_any;
    ill = m_illegal(we, f3, addr);
    present(we, f3, addr, wdata);
    e.acc   = cyc;
    e.err   = ill;
    e.rdata = (ill || we) ? 32'd0 : m_load(f3, addr, word);
    e.lat   = ill ? 2 : (we ? gd + 3 : gd + rd + 4);
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (ill) begin
      req_any = bus.mem_req;
      repeat (2) begin
        @(negedge clk);
        req_any = req_any | bus.mem_req;
      end
      check("no_bus_on_error", 32'(req_any), 32'd0);
    end else begin
      repeat (gd) @(negedge clk);
      check("mem_req", 32'(bus.mem_req), 32'd1);
      check("stall", 32'(bus.stall), 32'd1);
      check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
      check("mem_we", 32'(bus.mem_we), 32'(we));
      check("mem_wstrb", 32'(bus.mem_wstrb), we ? m_strb(f3, addr) : 32'd0);
      check("mem_wdata", bus.mem_wdata, we ? m_wdata(f3, wdata) : 32'd0);
      bus.mem_gnt = 1'b1;
      if (!we && early_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ~word;
      end
      @(negedge clk);
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!we) begin
        check("mem_req_wait", 32'(bus.mem_req), 32'd0);
        repeat (rd) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = word;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end
    drain();
  endtask

  initial begin : stimulus
    exp_t e;
    int   nreq;
    logic [2:0] f3;
    logic [31:0] a;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
    access(1'b0, 3'b100, 32'h0000_2002, 32'd0, 32'h9ABC_0000, 0, 0, 1'b0);
    access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h9ABC_0000, 0, 0, 1'b0);
    access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'd0, 0, 0, 1'b0);
    access(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0, 0, 1'b0);
    access(1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    access(1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 32'd0, 2, 0, 1'b0);
    access(1'b0, 3'b101, 32'h0000_0301, 32'd0, 32'h1234_5678, 1, 0, 1'b0);
    access(1'b0, 3'b010, 32'h0000_0204, 32'd0, 32'hCAFE_F00D, 2, 3, 1'b1);

    // Bus never grants: expect a timeout error and no response to late handshakes
    present(1'b0, 3'b010, 32'h0000_0040, 32'd0);
    e.acc   = cyc;
    e.err   = 1'b1;
    e.rdata = 32'd0;
    e.lat   = TO + 2;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    nreq = 0;
    for (int i = 0; i < TO + 4; i++) begin
      nreq += int'(bus.mem_req);
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(nreq), 32'(TO));
    check("timeout_resp_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting for read data drops the access silently
    present(1'b0, 3'b010, 32'h0000_0080, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("wait_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_stall", 32'(bus.stall), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    access(1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'h0BAD_F00D, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    drain();
    check("pending_at_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
